// File: rtl/seq_divider.sv
// seq_divider: sequential signed restoring divider, one quotient bit per
// enabled clock. Operands are captured as magnitudes. Sign correction
// (truncation toward zero) is applied when the last iteration completes.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   dividend     signed dividend, sampled on load
//   divisor      signed divisor, sampled on load
//   load         capture operands and start; has priority over enable
//   enable       advance one iteration per cycle; low stalls
//   result_sel   0: {remainder, quotient}; 1: sign-extended quotient
//   result       result selected from the registered quotient/remainder
//   sign         sign bit of the final quotient
//   zero_flag    final quotient == 0
//   div_by_zero  last division had divisor == 0
//   overflow     last division was MIN / -1
//   busy         high in RUN
//   done         high in DONE
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               load,
  input  logic               enable,
  input  logic               result_sel,
  output logic [2*WIDTH-1:0] result,
  output logic               sign,
  output logic               zero_flag,
  output logic               div_by_zero,
  output logic               overflow,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;          // dividend magnitude shifting into quotient
  logic [WIDTH-1:0] m_q, m_d;          // divisor magnitude
  logic [WIDTH:0]   p_q, p_d;          // partial remainder
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             divz_q, divz_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   p_sh, p_step;
  logic [WIDTH-1:0] a_step;
  logic             fits;
  logic [WIDTH-1:0] r_mag, q_fin, r_fin;

  always_comb begin
    dvd_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    dvs_mag = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;

    // One restoring step: shift {p, a} left, trial-subtract the divisor.
    p_sh   = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
    fits   = (p_sh >= {1'b0, m_q});
    p_step = fits ? (p_sh - {1'b0, m_q}) : p_sh;
    a_step = {a_q[WIDTH-2:0], fits};

    r_mag = p_step[WIDTH-1:0];
    q_fin = q_neg_q ? (~a_step + 1'b1) : a_step;
    r_fin = r_neg_q ? (~r_mag + 1'b1)  : r_mag;
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    m_d        = m_q;
    p_d        = p_q;
    cnt_d      = cnt_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    divz_d     = divz_q;
    ovf_pend_d = ovf_pend_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    sign_d     = sign_q;
    zero_d     = zero_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    if (load) begin
      divz_d     = (divisor == '0);
      // For a zero divisor the raw dividend is kept in a_q; it becomes the remainder.
      a_d        = (divisor == '0) ? dividend : dvd_mag;
      m_d        = dvs_mag;
      p_d        = '0;
      cnt_d      = '0;
      q_neg_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_d    = dividend[WIDTH-1];
      ovf_pend_d = (dividend == MIN_VAL) && (divisor == '1);
      dbz_d      = 1'b0;
      ovf_d      = 1'b0;
      state_d    = RUN;
    end else if (state_q == RUN) begin
      if (divz_q) begin
        quot_d  = '1;
        rem_d   = a_q;
        dbz_d   = 1'b1;
        sign_d  = 1'b1;
        zero_d  = 1'b0;
        ovf_d   = 1'b0;
        state_d = DONE;
      end else if (enable) begin
        p_d   = p_step;
        a_d   = a_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          quot_d  = q_fin;
          rem_d   = r_fin;
          sign_d  = q_fin[WIDTH-1];
          zero_d  = (q_fin == '0);
          ovf_d   = ovf_pend_q;
          state_d = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      m_q        <= '0;
      p_q        <= '0;
      cnt_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      divz_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      m_q        <= m_d;
      p_q        <= p_d;
      cnt_q      <= cnt_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      divz_q     <= divz_d;
      ovf_pend_q <= ovf_pend_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      sign_q     <= sign_d;
      zero_q     <= zero_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    result      = result_sel ? {{WIDTH{quot_q[WIDTH-1]}}, quot_q} : {rem_q, quot_q};
    sign        = sign_q;
    zero_flag   = zero_q;
    div_by_zero = dbz_q;
    overflow    = ovf_q;
    busy        = (state_q == RUN);
    done        = (state_q == DONE);
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential 8-bit signed restoring divider. It is the inverse-operation companion to the team's sequential multiplier.
- Shares the multiplier's control style: load/enable strobes, a selectable 16-bit result, and sign/zero flags.
- Divides dividend by divisor, one quotient bit per enabled clock.
- Sits beside the multiplier in the arithmetic datapath and feeds the same result/display path.

Parameters:
- WIDTH, 8, operand width in bits. Quotient and remainder are each WIDTH bits. Result is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- dividend  input  8  signed two's-complement dividend, sampled on load
- divisor  input  8  signed two's-complement divisor, sampled on load
- load  input  1  capture operands and start a division
- enable  input  1  advance one iteration per cycle while high; low stalls
- result_sel  input  1  0: result = {remainder, quotient}; 1: result = sign-extended quotient
- result  output  16  registered result per result_sel
- sign  output  1  sign bit of final quotient
- zero_flag  output  1  final quotient == 0
- div_by_zero  output  1  last division had divisor == 0
- overflow  output  1  last division was -128 / -1
- busy  output  1  high in RUN
- done  output  1  high in DONE

Behaviour:
- One clock (clk). Reset is synchronous and active-high.
- Reset forces the following regardless of other inputs, including mid-operation:
  - state = IDLE
  - result = 0, sign = 0, zero_flag = 0
  - div_by_zero = 0, overflow = 0, busy = 0, done = 0
  - internal registers cleared
- FSM states: IDLE, RUN, DONE.
- Load (any state, reset not asserted):
  - Captures |dividend| and |divisor| as 8-bit unsigned magnitudes (-128 maps to 128).
  - Captures q_neg = dividend[7] ^ divisor[7] and r_neg = dividend[7].
  - Clears the 9-bit partial remainder and the iteration counter.
  - Clears done, div_by_zero and overflow.
  - Next state: RUN; DIVZ path if divisor == 0 (see below).
- Load has priority over enable. A load while in RUN aborts the current division and restarts it.
- RUN step, on each rising edge with enable = 1:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude.
  - If the difference is non-negative, keep it and shift 1 into the quotient. Otherwise restore and shift 0.
  - Counter increments.
- enable = 0 in RUN: all state holds and busy stays 1.
- After the 8th step:
  - Apply sign correction: quotient negated if q_neg, remainder negated if r_neg (truncation toward zero).
  - Register result, sign, zero_flag, overflow.
  - Next state: DONE.
- Latency: done rises on the 8th enabled rising edge after the load edge. With enable held high, that is 8 cycles.
- DONE holds all outputs until the next load. Outputs are not updated during RUN; they keep their previous values.
- result_sel is combinational on the registered quotient/remainder:
  - 0: {remainder[7:0], quotient[7:0]}
  - 1: {{8{quotient[7]}}, quotient[7:0]}
- Divide by zero (divisor == 0 at load):
  - The next rising edge enters DONE directly, with no iterations.
  - quotient = 8'hFF, remainder = dividend (raw), div_by_zero = 1, sign = 1, zero_flag = 0.
- Overflow (-128 / -1):
  - The division runs normally; the 8-bit quotient wraps to 8'h80.
  - overflow = 1, remainder = 0, sign = 1.
- Simultaneous load and reset: reset wins.
- Simultaneous load and enable in RUN: load wins and no step is performed.

Test Plan:
- 100 / 7, result_sel = 0, enable high → done 8 cycles after load; result = 16'h020E (q = 14, r = 2); sign = 0, zero_flag = 0.
- -100 / 7 → q = 8'hF2, r = 8'hFE, result = 16'hFEF2. With result_sel = 1, result = 16'hFFF2. sign = 1.
- 7 / 0 → done one cycle after load; div_by_zero = 1, result = 16'h07FF. 3 / 5 → q = 0, r = 3, zero_flag = 1.
- -128 / -1 → overflow = 1, result = 16'h0080, sign = 1. -128 / 1 → q = 8'h80, overflow = 0.
- 100 / 7 with enable dropped for 3 cycles mid-run → busy stays 1, done arrives 11 cycles after load, result still 16'h020E.
- Load 50 / 3, then after 4 steps load 9 / 2 → restart; result = 16'h0104.
- Reset asserted mid-run → next edge: state IDLE, all outputs 0.
